// File: rtl/shared_count_arb_if.sv
// Requester-side bundle for shared_count_arb: requests, directions, bound and the count/grant results.
// Optional starve vector exists only when SHARED_CNT_STARVE_EN is defined.
interface shared_count_arb_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir;
    logic [WIDTH-1:0] max;
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
`ifdef SHARED_CNT_STARVE_EN
    logic [N_REQ-1:0] starve;

    modport master (output req, dir, max, input gnt, count, at_max, at_zero, starve);
    modport slave  (input req, dir, max, output gnt, count, at_max, at_zero, starve);
`else
    modport master (output req, dir, max, input gnt, count, at_max, at_zero);
    modport slave  (input req, dir, max, output gnt, count, at_max, at_zero);
`endif
endinterface

// File: rtl/shared_count_arb.sv
// Round-robin arbiter sharing one bounded up/down counter; one +/-1 step granted per cycle.
// Latency: gnt/count one cycle after eligibility; blocked requesters simply wait. Starve flags under SHARED_CNT_STARVE_EN.
module shared_count_arb #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 32,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk_ev,
    input  logic              rst,
    shared_count_arb_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 16 || STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_bad_param
        $error("shared_count_arb: parameter out of range");
    end

    logic [PTR_W-1:0] rr_ptr;
    logic [N_REQ-1:0] elig;
    logic             win_vld;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] gnt_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [PTR_W-1:0] ptr_nxt;

    // Masking the currently granted requester keeps a held req from a second grant.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req[i] && !bus.gnt[i] &&
                      (bus.dir[i] ? (bus.count < bus.max) : (bus.count != '0));
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_nxt   = '0;
        count_nxt = bus.count;
        ptr_nxt   = rr_ptr;
        if (win_vld) begin
            gnt_nxt = N_REQ'(1) << win_idx;
            if (bus.dir[win_idx]) begin
                count_nxt = bus.count + WIDTH'(1);
            end else begin
                count_nxt = bus.count - WIDTH'(1);
            end
            ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_ev) begin
        if (rst) begin
            bus.count   <= '0;
            bus.gnt     <= '0;
            bus.at_max  <= (bus.max == '0);
            bus.at_zero <= 1'b1;
            rr_ptr      <= '0;
        end else begin
            bus.count   <= count_nxt;
            bus.gnt     <= gnt_nxt;
            bus.at_max  <= (count_nxt >= bus.max);
            bus.at_zero <= (count_nxt == '0);
            rr_ptr      <= ptr_nxt;
        end
    end

`ifdef SHARED_CNT_STARVE_EN
    logic [7:0] wait_cnt [N_REQ];
    logic [7:0] wait_nxt [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            wait_nxt[i] = wait_cnt[i];
            if (!bus.req[i] || bus.gnt[i]) begin
                wait_nxt[i] = '0;
            end else if (wait_cnt[i] != 8'hFF) begin
                wait_nxt[i] = wait_cnt[i] + 8'd1;
            end
        end
    end

    // Flag follows the updated wait value so it rises on the edge the limit is reached.
    always_ff @(posedge clk_ev) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            bus.starve <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt[i]   <= wait_nxt[i];
                bus.starve[i] <= (wait_nxt[i] >= 8'(STARVE_LIM));
            end
        end
    end
`endif
endmodule
